spart_rx_fifo: RTL and testbench
================================

// Module: spart_rx_fifo
// PURPOSE
//  Receive-side buffer directly downstream of the SPART receiver. Captures each completed
//  10-bit frame on the receiver's rx_done pulse, strips start/stop bits and stores the
//  8 data bits in a small FIFO. The bus interface drains it one byte per rd_en pulse.
//  Reports data-available, occupancy and a sticky overrun flag for the status register.
// PARAMETERS
//  DEPTH   8   FIFO entries; power of 2, >= 2
//  DATA_W  8   stored data width; fixed at 8 (frame = start + 8 data + stop)
// PORTS
//  clk           in   1            system clock; all state on posedge
//  rst           in   1            asynchronous, active-high reset
//  rx_done       in   1            receiver frame-complete strobe (stop bit already checked high)
//  rx_shift_reg  in   10           received frame: [0]=start, [8:1]=data LSB-first, [9]=stop
//  rd_en         in   1            bus pop request, one byte per high cycle
//  clr_ovr       in   1            clears the overrun flag
//  rx_data       out  8            head-of-FIFO byte (first-word fall-through)
//  rda           out  1            receive data available (count != 0)
//  rx_count      out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  overrun       out  1            sticky: a frame was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset (async, rst=1): wr_ptr=rd_ptr=0, count=0, overrun=0; outputs rx_data=8'h00,
//    rda=0, rx_count=0. Memory contents are not cleared.
//  - Reset mid-operation discards all stored bytes; the first rx_done after release is
//    stored at entry 0.
//  - Push: every clk cycle with rx_done=1 is one frame. If the FIFO is not full, or it is
//    full and rd_en=1 in the same cycle, write rx_shift_reg[8:1] at wr_ptr and increment
//    wr_ptr. rx_done is sampled only as a level; no edge detection.
//  - Pop: rd_en=1 with count!=0 increments rd_ptr. rd_en with count==0 is ignored; no
//    pointer move and no error.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
//  - Count: +1 on push only, -1 on pop only, unchanged on push+pop or neither. Range is
//    0..DEPTH; it never wraps.
//  - Simultaneous push and pop:
//    - empty: the push is accepted and the pop is ignored, so count becomes 1;
//    - full: both are accepted, count stays DEPTH, and no overrun is raised.
//  - Overrun: rx_done=1 while full and rd_en=0 drops the frame; memory and pointers are
//    unchanged; overrun <= 1 next edge.
//    - It stays set until clr_ovr=1.
//    - If set and clr_ovr occur in the same cycle, set wins.
//  - rx_data = mem[rd_ptr] when count!=0, else 8'h00. It is combinational from the
//    registered state and changes the cycle after a pop.
//  - Latency: a byte pushed at edge N appears on rx_data with rda=1 after edge N (zero
//    extra cycles).
//  - rda = (count != 0); rx_count = count. Both are registered-state derived and
//    glitch-free for the bus.
// STRUCTURE
//  - The shared package spart_pkg holds:
//    - SPART_DATA_W=8 and SPART_FRAME_W=10;
//    - frame bit-index constants START_BIT=0, DATA_LSB=1, DATA_MSB=8, STOP_BIT=9;
//    - these are shared with the receiver and transmitter.
//  - Flat module with no sub-module: memory array, two pointers, count register and
//    overrun flop. The push/pop qualifiers (push_ok, pop_ok) are explicit
//    combinational signals.
// TESTING
//  1. Reset, then one rx_done with rx_shift_reg=10'b1_1010_0101_0 -> rda=1, rx_data=8'hA5,
//     rx_count=1.
//  2. Push 8'h01..8'h08 (DEPTH=8), then 8 rd_en pulses -> rx_data reads 01..08 in order;
//     count 8->0; rda=0, rx_data=00.
//  3. Full FIFO, rx_done with data 8'hFF and rd_en=0 -> overrun=1, count=8, head unchanged;
//     clr_ovr -> overrun=0.
//  4. Full FIFO, rx_done(8'h5A) and rd_en in the same cycle -> count=8, overrun=0,
//     8'h5A is last out.
//  5. Empty FIFO, rd_en alone -> no change; rd_en+rx_done(8'h3C) -> count=1,
//     rx_data=8'h3C.
//  6. After 12 push/pop pairs (pointer wrap), then rst pulse mid-stream -> count=0, rda=0,
//     overrun=0; next push lands at entry 0.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared SPART definitions: data/frame widths and frame bit positions,
// common to the receiver, transmitter and receive FIFO.
package spart_pkg;

  localparam int SPART_DATA_W  = 8;
  localparam int SPART_FRAME_W = 10;

  // Frame layout: start bit, eight data bits LSB-first, stop bit.
  localparam int START_BIT = 0;
  localparam int DATA_LSB  = 1;
  localparam int DATA_MSB  = 8;
  localparam int STOP_BIT  = 9;

  // Strip start/stop bits from a received frame.
  function automatic logic [SPART_DATA_W-1:0] frame_data(
    input logic [SPART_FRAME_W-1:0] frame
  );
    return frame[DATA_MSB:DATA_LSB];
  endfunction

endpackage

// File: rtl/spart_rx_fifo.sv
// SPART receive buffer: captures each completed frame on rx_done, stores
// its data byte in a first-word fall-through FIFO drained by rd_en, and
// reports availability, occupancy and a sticky overrun flag.
module spart_rx_fifo
  import spart_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = SPART_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_done,
  input  logic [SPART_FRAME_W-1:0] rx_shift_reg,
  input  logic                     rd_en,
  input  logic                     clr_ovr,
  output logic [DATA_W-1:0]        rx_data,
  output logic                     rda,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     overrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic full;
  logic empty;
  logic push_ok;
  logic pop_ok;
  logic drop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A full FIFO still accepts a frame when the same cycle frees an entry.
  assign push_ok = rx_done && (!full || rd_en);
  assign pop_ok  = rd_en && !empty;
  assign drop    = rx_done && full && !rd_en;

  // Data storage, written only on an accepted frame.
  // NOTE: the memory array has no reset; stale contents are never visible
  // because rx_data is gated by count, and leaving it unreset keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= frame_data(rx_shift_reg);
    end
  end

  // Pointers and occupancy; pointers wrap modulo DEPTH, count saturates by construction.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
    end
  end

  // Sticky overrun: a dropped frame sets it, clr_ovr clears it, set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

  // Head-of-FIFO byte, forced to zero when nothing is stored.
  // NOTE: the default assignment first guarantees no latch is inferred.
  always_comb begin
    rx_data = '0;
    if (!empty) begin
      rx_data = mem[rd_ptr];
    end
  end

  assign rda      = !empty;
  assign rx_count = count;

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Self-checking bench for spart_rx_fifo: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_spart_rx_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_done;
  logic [9:0] rx_shift_reg;
  logic       rd_en;
  logic       clr_ovr;
  logic [7:0] rx_data;
  logic       rda;
  logic [3:0] rx_count;
  logic       overrun;

  spart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_done      (rx_done),
    .rx_shift_reg (rx_shift_reg),
    .rd_en        (rd_en),
    .clr_ovr      (clr_ovr),
    .rx_data      (rx_data),
    .rda          (rda),
    .rx_count     (rx_count),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored bytes and the overrun bit.
  logic [7:0] model_q[$];
  logic       model_ovr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_data;
    exp_data = (model_q.size() != 0) ? model_q[0] : 8'h00;
    check({tag, "_data"},  32'(rx_data),  32'(exp_data));
    check({tag, "_rda"},   32'(rda),      32'(model_q.size() != 0));
    check({tag, "_count"}, 32'(rx_count), 32'(model_q.size()));
    check({tag, "_ovr"},   32'(overrun),  32'(model_ovr));
  endtask

  // One clock cycle of stimulus; the model applies the buffer's rules.
  task automatic cycle(input logic d, input logic [9:0] frame, input logic r, input logic c);
    bit is_full;
    @(negedge clk);
    rx_done      = d;
    rx_shift_reg = frame;
    rd_en        = r;
    clr_ovr      = c;
    is_full = (model_q.size() == DEPTH);
    if (r && model_q.size() != 0) void'(model_q.pop_front());
    if (d && (!is_full || r)) model_q.push_back(frame[8:1]);
    if (d && is_full && !r) model_ovr = 1'b1;
    else if (c)             model_ovr = 1'b0;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rd_en   = 1'b0;
    clr_ovr = 1'b0;
  endtask

  function automatic logic [9:0] mk(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  initial begin
    logic [7:0] b;
    rst = 1'b1;
    rx_done = 1'b0;
    rx_shift_reg = '0;
    rd_en = 1'b0;
    clr_ovr = 1'b0;
    model_ovr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: single frame, data bits stripped from start/stop.
    cycle(1'b1, 10'b1_1010_0101_0, 1'b0, 1'b0);
    check("t1_a5", 32'(rx_data), 32'h0000_00A5);
    check_all("t1");
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_all("t1_pop");

    // 2: fill with 01..08, drain in order.
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, mk(8'(i)), 1'b0, 1'b0);
      check_all("t2_push");
    end
    for (int i = 1; i <= DEPTH; i++) begin
      check("t2_order", 32'(rx_data), 32'(i));
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_all("t2_pop");
    end

    // 3: overrun on full, head preserved; set beats clear; clear works.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, mk(8'($urandom)), 1'b0, 1'b0);
    b = rx_data;
    cycle(1'b1, mk(8'hFF), 1'b0, 1'b0);
    check("t3_ovr", 32'(overrun), 32'd1);
    check("t3_head", 32'(rx_data), 32'(b));
    check_all("t3");
    cycle(1'b1, mk(8'hEE), 1'b0, 1'b1);
    check_all("t3_setwins");
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("t3_clr", 32'(overrun), 32'd0);
    check_all("t3_clr");

    // 4: push and pop together on full: no overrun, 5A comes out last.
    cycle(1'b1, mk(8'h5A), 1'b1, 1'b0);
    check("t4_count", 32'(rx_count), 32'(DEPTH));
    check_all("t4");
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("t4_last", 32'(rx_data), 32'h5A);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_all("t4_drain");
    end

    // 5: empty pop ignored; push+pop on empty keeps the push.
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_all("t5_emptypop");
    cycle(1'b1, mk(8'h3C), 1'b1, 1'b0);
    check("t5_data", 32'(rx_data), 32'h3C);
    check_all("t5");

    // 6: pointer wrap via push/pop pairs.
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, mk(8'($urandom)), 1'b1, 1'b0);
      check_all("t6_pair");
    end

    // Random traffic, biased so the FIFO visits both empty and full.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), {1'b1, 8'($urandom), 1'b0},
            1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 10));
      check_all("rand");
    end

    // Mid-stream asynchronous reset.
    cycle(1'b1, mk(8'h11), 1'b0, 1'b0);
    cycle(1'b1, mk(8'h22), 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    model_q.delete();
    model_ovr = 1'b0;
    check_all("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, mk(8'h77), 1'b0, 1'b0);
    check("t6_entry0", 32'(dut.mem[0]), 32'h77);
    check_all("t6_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
